ssd_scan_driver: RTL and testbench

//  Time-multiplexes four pre-encoded 7-segment digit patterns onto one shared segment bus and four

---
 rtl/ssd_scan_driver_if.sv | 40 ++++
 rtl/ssd_scan_driver.sv | 128 ++++++++++++
 tb/tb_ssd_scan_driver.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/ssd_scan_driver_if.sv
// -----------------------------------------------------------------------------
// ssd_scan_driver_if
// Purpose : Bundles the digit-word inputs, display enable and board-pin outputs
//           of the 7-segment scan driver into one connection.
// Signals : sSegAN0..3  8b  digit words (bits[7:1]=g..a, bit0=dp, active-low)
//           en          1b  display enable
//           brightness  4b  PWM duty (only when SSD_DIMMING_EN is defined)
//           seg         7b  segments g..a, active-low
//           dp          1b  decimal point, active-low
//           an          4b  anodes, an[0]=AN0, active-low
//           frame_start 1b  pulse at first output cycle of each digit-0 slot
// Modports: master = word source / pin consumer, slave = scan driver.
// Config  : SSD_DIMMING_EN adds the brightness signal.
// -----------------------------------------------------------------------------
interface ssd_scan_driver_if;
   logic [7:0] sSegAN0;
   logic [7:0] sSegAN1;
   logic [7:0] sSegAN2;
   logic [7:0] sSegAN3;
   logic       en;
`ifdef SSD_DIMMING_EN
   logic [3:0] brightness;
`endif
   logic [6:0] seg;
   logic       dp;
   logic [3:0] an;
   logic       frame_start;

`ifdef SSD_DIMMING_EN
   modport master (output sSegAN0, sSegAN1, sSegAN2, sSegAN3, en, brightness,
                   input  seg, dp, an, frame_start);
   modport slave  (input  sSegAN0, sSegAN1, sSegAN2, sSegAN3, en, brightness,
                   output seg, dp, an, frame_start);
`else
   modport master (output sSegAN0, sSegAN1, sSegAN2, sSegAN3, en,
                   input  seg, dp, an, frame_start);
   modport slave  (input  sSegAN0, sSegAN1, sSegAN2, sSegAN3, en,
                   output seg, dp, an, frame_start);
`endif
endinterface

// File: rtl/ssd_scan_driver.sv
// -----------------------------------------------------------------------------
// ssd_scan_driver
// Purpose : Time-multiplexes four pre-encoded 7-segment digit words onto a shared
//           active-low segment bus and four active-low anodes. The four words
//           are snapshotted once per frame so a frame never mixes samples, and
//           the first BLANK_CYCLES of every digit slot keep all anodes off to
//           suppress ghosting. All pins are registered (one clock lag).
// Ports   : clk     system clock
//           rst     asynchronous, active-high reset
//           if_ssd  ssd_scan_driver_if.slave (words, en, [brightness], pins)
// Params  : REFRESH_DIV  clocks per digit slot (>=2)
//           BLANK_CYCLES blanked clocks at the start of each slot
// Config  : SSD_DIMMING_EN adds a free-running 4-bit PWM counter; in the
//           non-blank window the anode is on only while pwm <= brightness.
// -----------------------------------------------------------------------------
module ssd_scan_driver #(
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic              clk,
   input  logic              rst,
   ssd_scan_driver_if.slave  if_ssd
);

   localparam int CW = $clog2(REFRESH_DIV);
   typedef logic [CW-1:0] cnt_t;
   localparam cnt_t CNT_LAST = cnt_t'(REFRESH_DIV - 1);

   cnt_t       r_cnt;
   logic [1:0] r_digit;
   logic [7:0] r_snap [4];
   logic       r_primed;   // set once the first real snapshot has been taken

   logic [3:0] r_an;
   logic [6:0] r_seg;
   logic       r_dp;
   logic       r_frame_start;

   logic       w_wrap;
   logic       w_blank;
   logic       w_anode_on;
   logic [7:0] w_word;
   logic [3:0] w_an_nxt;
   logic [6:0] w_seg_nxt;
   logic       w_dp_nxt;

   assign w_wrap  = (r_cnt == CNT_LAST);
   assign w_blank = (int'(r_cnt) < BLANK_CYCLES);
   assign w_word  = r_snap[r_digit];

`ifdef SSD_DIMMING_EN
   logic [3:0] r_pwm;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_pwm <= 4'd0;
      else     r_pwm <= r_pwm + 4'd1;
   end

   assign w_anode_on = (r_pwm <= if_ssd.brightness);
`else
   assign w_anode_on = 1'b1;
`endif

   // Slot counter, digit index and frame snapshot.
   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt    <= '0;
         r_digit  <= 2'd0;
         // NOTE: this small storage array is reset on purpose: the frame that
         // follows reset must read as blank (8'hFF) rather than X.
         r_snap   <= '{default: 8'hFF};
         r_primed <= 1'b0;
      end else if (w_wrap) begin
         r_cnt   <= '0;
         r_digit <= r_digit + 2'd1;
         if (r_digit == 2'd3) begin
            // Capture on the edge that starts the next frame, so all four
            // words displayed in that frame come from the same instant.
            r_snap[0] <= if_ssd.sSegAN0;
            r_snap[1] <= if_ssd.sSegAN1;
            r_snap[2] <= if_ssd.sSegAN2;
            r_snap[3] <= if_ssd.sSegAN3;
            r_primed  <= 1'b1;
         end
      end else begin
         r_cnt <= r_cnt + cnt_t'(1);
      end
   end

   // Next pin values from the current slot position.
   // NOTE: every output of this block gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      w_an_nxt  = 4'b1111;
      w_seg_nxt = 7'h7F;
      w_dp_nxt  = 1'b1;
      // Nothing lights until the first snapshot exists: the frame right
      // after reset stays fully dark, anodes included.
      if (!w_blank && r_primed && if_ssd.en) begin
         w_seg_nxt = w_word[7:1];
         w_dp_nxt  = w_word[0];
         if (w_anode_on) w_an_nxt = ~(4'b0001 << r_digit);
      end
   end

   // Registered pins: no combinational path from any input to the board.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_an          <= 4'b1111;
         r_seg         <= 7'h7F;
         r_dp          <= 1'b1;
         r_frame_start <= 1'b0;
      end else begin
         r_an          <= w_an_nxt;
         r_seg         <= w_seg_nxt;
         r_dp          <= w_dp_nxt;
         r_frame_start <= (r_cnt == '0) && (r_digit == 2'd0);
      end
   end

   assign if_ssd.an          = r_an;
   assign if_ssd.seg         = r_seg;
   assign if_ssd.dp          = r_dp;
   assign if_ssd.frame_start = r_frame_start;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_ssd_scan_driver
// Purpose : Directed check of ssd_scan_driver with REFRESH_DIV=8, BLANK_CYCLES=2
//           (32-clock frames). Each frame's expected pins are held in a 32-entry
//           table of {en, an, seg, dp, frame_start} records built from
//           hand-computed segment constants; mid-frame input changes, enable
//           drop and asynchronous reset are exercised as short sequences.
// -----------------------------------------------------------------------------
module tb_ssd_scan_driver;

   typedef struct {
      logic       en;
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      logic       fs;
   } vec_t;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_bad;
   vec_t tbl [32];

   // Anode pattern per digit slot, hand-written.
   logic [3:0] an_k [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

   // First word set and its hand-decoded segments / dp.
   logic [7:0] w_a   [4] = '{8'b10000001, 8'b11110011, 8'b01001000, 8'b00100001};
   logic [6:0] seg_a [4] = '{7'h40, 7'h79, 7'h24, 7'h10};
   logic       dp_a  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};

   // Second word set: 03 -> 01/1, FE -> 7F/0, 0C -> 06/0, 55 -> 2A/1.
   logic [7:0] w_b   [4] = '{8'h03, 8'hFE, 8'h0C, 8'h55};
   logic [6:0] seg_b [4] = '{7'h01, 7'h7F, 7'h06, 7'h2A};
   logic       dp_b  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

   ssd_scan_driver_if dut_if ();

   ssd_scan_driver #(
      .REFRESH_DIV  (8),
      .BLANK_CYCLES (2)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .if_ssd (dut_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int idx,
                        input logic [12:0] act, input logic [12:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s[%0d]: got an=%b seg=%h dp=%b fs=%b, want an=%b seg=%h dp=%b fs=%b",
                  name, idx, act[12:9], act[8:2], act[1], act[0],
                  exp[12:9], exp[8:2], exp[1], exp[0]);
      end
   endtask

   task automatic set_words(input logic [7:0] w [4]);
      dut_if.sSegAN0 = w[0];
      dut_if.sSegAN1 = w[1];
      dut_if.sSegAN2 = w[2];
      dut_if.sSegAN3 = w[3];
   endtask

   // Expected frame: 2 blank cycles then 6 lit cycles per slot; frame_start
   // on the first output cycle of the frame. Unprimed frames stay dark.
   function automatic void fill(input logic [6:0] s [4], input logic d [4], input bit lit);
      for (int o = 0; o < 32; o++) begin
         tbl[o].en  = 1'b1;
         tbl[o].fs  = (o == 0);
         tbl[o].an  = 4'b1111;
         tbl[o].seg = 7'h7F;
         tbl[o].dp  = 1'b1;
         if (lit && (o % 8) >= 2) begin
            tbl[o].an  = an_k[o / 8];
            tbl[o].seg = s[o / 8];
            tbl[o].dp  = d[o / 8];
         end
      end
   endfunction

   // Apply en for each cycle, let one clock pass, compare at the negedge.
   task automatic run(input string name, input int lo, input int hi);
      for (int o = lo; o <= hi; o++) begin
         dut_if.en = tbl[o].en;
         @(negedge clk);
         check(name, o, {dut_if.an, dut_if.seg, dut_if.dp, dut_if.frame_start},
               {tbl[o].an, tbl[o].seg, tbl[o].dp, tbl[o].fs});
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst   = 1'b1;
      dut_if.en = 1'b1;
`ifdef SSD_DIMMING_EN
      dut_if.brightness = 4'hF;
`endif
      set_words(w_a);

      // Reset state while rst is held.
      #2;
      check("reset", 0, {dut_if.an, dut_if.seg, dut_if.dp, dut_if.frame_start},
            {4'b1111, 7'h7F, 1'b1, 1'b0});
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Frame after reset: dark, frame_start still pulses.
      fill(seg_a, dp_a, 1'b0);
      run("blank", 0, 31);

      // Held words shown in the next frame.
      fill(seg_a, dp_a, 1'b1);
      run("scan", 0, 31);

      // Inputs changed mid-frame: this frame still shows the old snapshot.
      run("hold", 0, 11);
      set_words(w_b);
      run("hold", 12, 31);

      // New snapshot, with en dropped from digit1 cycle 4 to digit2 cycle 3.
      fill(seg_b, dp_b, 1'b1);
      for (int o = 12; o <= 19; o++) begin
         tbl[o].en  = 1'b0;
         tbl[o].an  = 4'b1111;
         tbl[o].seg = 7'h7F;
         tbl[o].dp  = 1'b1;
      end
      run("en_gate", 0, 31);

      // Async reset at digit2 cycle 5, away from any clock edge.
      fill(seg_b, dp_b, 1'b1);
      run("pre_rst", 0, 20);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst", 21, {dut_if.an, dut_if.seg, dut_if.dp, dut_if.frame_start},
            {4'b1111, 7'h7F, 1'b1, 1'b0});
      @(negedge clk);
      check("rst_hold", 0, {dut_if.an, dut_if.seg, dut_if.dp, dut_if.frame_start},
            {4'b1111, 7'h7F, 1'b1, 1'b0});
      rst = 1'b0;

      // Scan restarts at digit 0 with a dark frame, then the held words.
      fill(seg_b, dp_b, 1'b0);
      run("post_rst_blank", 0, 31);
      fill(seg_b, dp_b, 1'b1);
      run("post_rst_scan", 0, 31);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
